// File: rtl/conv_seq_pkg.sv
// Shared defaults and FSM state encoding for the convolution frame sequencer.
package conv_seq_pkg;
  localparam int DEF_IMG_W  = 50;
  localparam int DEF_IMG_H  = 50;
  localparam int DEF_N_PIX  = DEF_IMG_W * DEF_IMG_H;
  localparam int DEF_PIX_W  = 12;
  localparam int DEF_ADDR_W = 17;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;
endpackage

// File: rtl/conv_seq_drain.sv
// Output-buffer drain: issues one read, presents the result, waits for the
// handshake, then moves to the next address (at most one pixel per 2 cycles).
module conv_seq_drain
  import conv_seq_pkg::*;
#(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_PIX  = DEF_N_PIX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  output logic [ADDR_W-1:0] ob_addr,
  input  logic [PIX_W-1:0]  ob_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_data,
  output logic              last_acc
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_PIX - 1);

  logic [ADDR_W-1:0] k;
  logic              vld, held;
  logic [PIX_W-1:0]  hold_q;

  assign ob_addr   = k;
  assign out_valid = vld;
  // Capture read data on the first stalled cycle so the beat stays stable
  // regardless of what the buffer does while we wait.
  assign out_data  = !vld ? '0 : (held ? hold_q : ob_rdata);
  assign last_acc  = vld & out_ready & (k == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k      <= '0;
      vld    <= 1'b0;
      held   <= 1'b0;
      hold_q <= '0;
    end else if (clr) begin
      k    <= '0;
      vld  <= 1'b0;
      held <= 1'b0;
    end else if (vld) begin
      if (out_ready) begin
        vld  <= 1'b0;
        held <= 1'b0;
        if (k != LAST) k <= k + ADDR_W'(1);
      end else if (!held) begin
        held   <= 1'b1;
        hold_q <= ob_rdata;
      end
    end else if (en) begin
      vld <= 1'b1;
    end
  end
endmodule

// File: rtl/conv_frame_seq.sv
// Frame sequencer: load host pixels into the input buffer, kick the
// convolution engine, wait for it, then stream the output buffer back.
module conv_frame_seq
  import conv_seq_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int PIX_W   = DEF_PIX_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = 1048575
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  in_data,
  output logic              ib_we,
  output logic [ADDR_W-1:0] ib_addr,
  output logic [PIX_W-1:0]  ib_wdata,
  output logic              conv_start,
  input  logic              conv_ready,
  output logic [ADDR_W-1:0] ob_addr,
  input  logic [PIX_W-1:0]  ob_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);
  localparam int N_PIX = IMG_W * IMG_H;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(N_PIX - 1);
  localparam logic [TW-1:0]     TO_LAST = TW'(TIMEOUT - 1);

  state_t            state, nxt;
  logic [ADDR_W-1:0] pix_cnt;
  logic [TW-1:0]     wait_cnt;
  logic              rdy_q, beat, rise, tmo, last_acc, drain_clr;

  assign beat      = in_valid & in_ready;
  assign ib_we     = beat;
  assign ib_addr   = pix_cnt;
  assign ib_wdata  = beat ? in_data : '0;
  // Only a fresh rising edge counts; a level left high from a previous run is ignored.
  assign rise      = conv_ready & ~rdy_q;
  assign tmo       = (state == S_WAIT) & ~rise & (wait_cnt == TO_LAST);
  assign drain_clr = (nxt == S_DRAIN) & (state != S_DRAIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt        = state;
    in_ready   = 1'b0;
    conv_start = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (go) nxt = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && pix_cnt == LAST) nxt = S_START;
      end
      S_START: begin
        conv_start = 1'b1;
        nxt        = S_WAIT;
      end
      S_WAIT: begin
        if (rise)     nxt = S_DRAIN;
        else if (tmo) nxt = S_IDLE;
      end
      S_DRAIN: if (last_acc) nxt = S_DONE;
      S_DONE: begin
        frame_done = 1'b1;
        nxt        = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt  <= '0;
      wait_cnt <= '0;
      rdy_q    <= 1'b0;
      err      <= 1'b0;
    end else begin
      rdy_q    <= conv_ready;
      wait_cnt <= (state == S_WAIT) ? wait_cnt + TW'(1) : '0;
      if (state == S_IDLE && go) begin
        pix_cnt <= '0;
        err     <= 1'b0;
      end else if (beat && pix_cnt != LAST) begin
        pix_cnt <= pix_cnt + ADDR_W'(1);
      end
      if (tmo) err <= 1'b1;
    end
  end

  conv_seq_drain #(
    .PIX_W (PIX_W),
    .ADDR_W(ADDR_W),
    .N_PIX (N_PIX)
  ) u_drain (
    .clk      (clk),
    .rst      (rst),
    .en       (state == S_DRAIN),
    .clr      (drain_clr),
    .ob_addr  (ob_addr),
    .ob_rdata (ob_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .last_acc (last_acc)
  );
endmodule

// File: tb/tb_conv_frame_seq.sv
// Scoreboard bench for conv_frame_seq: random pixels, random out_ready,
// buffer models, timeout, mid-load reset and ignored go pulses.
module tb_conv_frame_seq;
  import conv_seq_pkg::*;

  localparam int AW  = DEF_ADDR_W;
  localparam int PW  = DEF_PIX_W;
  localparam int N   = DEF_N_PIX;
  localparam int TMO = 100;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [PW-1:0] d;
  } wr_t;

  logic          clk = 1'b0, rst = 1'b0, go = 1'b0, in_valid = 1'b0;
  logic [PW-1:0] in_data = '0, ob_rdata = '0, ib_wdata, out_data;
  logic [AW-1:0] ib_addr, ob_addr;
  logic          in_ready, ib_we, conv_start, conv_ready = 1'b0;
  logic          out_valid, out_ready = 1'b0, busy, frame_done, err;

  conv_frame_seq #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .go(go), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .ib_we(ib_we), .ib_addr(ib_addr), .ib_wdata(ib_wdata),
    .conv_start(conv_start), .conv_ready(conv_ready), .ob_addr(ob_addr),
    .ob_rdata(ob_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  // Output buffer model: synchronous read, one cycle latency.
  logic [PW-1:0] ob_mem [N];
  always @(posedge clk) ob_rdata <= (int'(ob_addr) < N) ? ob_mem[ob_addr] : '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  wr_t           ib_q[$];
  logic [PW-1:0] out_q[$];

  // Monitor: all DUT-side observation and scoreboard popping happens here.
  int            n_start = 0, n_done = 0, n_ov = 0;
  int            last_beat_cyc = -10, last_acc_cyc = -10;
  logic          stall_q = 1'b0;
  logic [PW-1:0] stall_d = '0;
  wr_t           mon_e;
  logic [PW-1:0] mon_d;
  always @(negedge clk) begin
    if (!rst) begin
      stall_q = 1'b0;
    end else begin
      if (ib_we) begin
        if (ib_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ib_spurious_we: addr %0d written with no beat issued", ib_addr);
        end else begin
          mon_e = ib_q.pop_front();
          check("ib_addr", 64'(ib_addr), 64'(mon_e.a));
          check("ib_wdata", 64'(ib_wdata), 64'(mon_e.d));
          if (int'(ib_addr) == N - 1) last_beat_cyc = cyc;
        end
      end
      if (conv_start) begin
        n_start++;
        check("start_latency", 64'(cyc - last_beat_cyc), 64'd1);
      end
      if (stall_q) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(stall_d));
      end
      if (out_valid) n_ov++;
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL out_extra: pixel %0h delivered with none expected", out_data);
        end else begin
          mon_d = out_q.pop_front();
          check("out_data", 64'(out_data), 64'(mon_d));
          if (out_q.size() == 0) last_acc_cyc = cyc;
        end
      end
      if (frame_done) begin
        n_done++;
        check("done_latency", 64'(cyc - last_acc_cyc), 64'd1);
      end
      stall_q = out_valid & ~out_ready;
      stall_d = out_data;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_go();
    go = 1'b1; tick(); go = 1'b0;
  endtask

  // Expected drain contents are simply the whole buffer in raster order.
  task automatic fill_ob(input bit expect_drain);
    for (int i = 0; i < N; i++) begin
      ob_mem[i] = PW'($urandom);
      if (expect_drain) out_q.push_back(ob_mem[i]);
    end
  endtask

  task automatic load(input int nbeats, input int gap_pct);
    int b = 0;
    while (b < nbeats) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data  = PW'($urandom);
      if (in_valid) begin
        ib_q.push_back('{a: AW'(b), d: in_data});
        b++;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    int s0 = n_start;
    for (int i = 0; i < budget && n_start == s0; i++) begin @(negedge clk); #1; end
    check("conv_start_seen", 64'(n_start - s0), 64'd1);
  endtask

  task automatic wait_done(input int budget);
    int d0 = n_done;
    for (int i = 0; i < budget && n_done == d0; i++) begin @(negedge clk); #1; end
    check("frame_done_seen", 64'(n_done - d0), 64'd1);
  endtask

  initial begin
    int s0, d0, ov0, ov_rise, rise_cyc, w;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", 64'({in_ready, ib_we, conv_start, out_valid, busy, frame_done, err}), 64'd0);
    check("reset_ib", 64'({ib_addr, ib_wdata}), 64'd0);
    check("reset_ob", 64'({ob_addr, out_data}), 64'd0);
    @(negedge clk); rst = 1'b1;
    tick();

    // Frame A: unbroken load, engine level already high, go pulses mid-frame.
    conv_ready = 1'b1;
    fill_ob(1'b1);
    s0 = n_start; d0 = n_done;
    pulse_go();
    load(N, 0);
    wait_start(20);
    ov0 = n_ov;
    tick(); go = 1'b1; tick(); go = 1'b0;
    repeat (3) tick();
    conv_ready = 1'b0;
    repeat (3) tick();
    conv_ready = 1'b1;
    rise_cyc = cyc; ov_rise = n_ov;
    check("no_drain_on_level", 64'(ov_rise - ov0), 64'd0);
    for (int i = 0; i < 20 && !out_valid; i++) begin @(negedge clk); #1; end
    check("drain_on_rise", 64'(cyc - rise_cyc), 64'd2);
    repeat (50) tick();
    pulse_go();
    wait_done(12000);
    check("frameA_pixels_left", 64'(out_q.size()), 64'd0);
    check("frameA_starts", 64'(n_start - s0), 64'd1);
    repeat (3) tick();
    check("frameA_done_count", 64'(n_done - d0), 64'd1);
    check("frameA_idle_after", 64'(busy), 64'd0);

    // Timeout frame: engine never answers.
    conv_ready = 1'b0;
    fill_ob(1'b0);
    d0 = n_done;
    pulse_go();
    load(N, 0);
    wait_start(20);
    check("err_before_timeout", 64'(err), 64'd0);
    w = 0;
    for (int i = 0; i < 300 && busy; i++) begin @(negedge clk); #1; if (busy) w++; end
    check("timeout_cycles", 64'(w), 64'(TMO));
    check("timeout_err", 64'(err), 64'd1);
    check("timeout_no_done", 64'(n_done - d0), 64'd0);

    // Next go clears err; abort the load with reset part-way through.
    tick();
    pulse_go();
    check("err_cleared_by_go", 64'({err, busy}), 64'b01);
    load(1200, 0);
    check("abort_ib_q", 64'(ib_q.size()), 64'd0);
    in_valid = 1'b1; in_data = PW'($urandom);
    rst = 1'b0;
    #1;
    check("abort_reset_flags", 64'({in_ready, ib_we, conv_start, out_valid, busy, frame_done, err}), 64'd0);
    check("abort_reset_ib", 64'({ib_addr, ib_wdata}), 64'd0);
    check("abort_reset_ob", 64'({ob_addr, out_data}), 64'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);

    // Fresh frame: go presented as reset lifts, gappy input, late engine.
    fill_ob(1'b1);
    d0 = n_done; s0 = n_start;
    @(negedge clk); rst = 1'b1; go = 1'b1;
    tick(); go = 1'b0;
    check("go_after_reset", 64'(busy), 64'd1);
    load(N, 30);
    wait_start(20);
    repeat (4) tick();
    conv_ready = 1'b1;
    wait_done(12000);
    check("frameC_pixels_left", 64'(out_q.size()), 64'd0);
    check("frameC_starts", 64'(n_start - s0), 64'd1);
    repeat (3) tick();
    check("frameC_done_count", 64'(n_done - d0), 64'd1);
    check("final_ib_q", 64'(ib_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_frame_seq.md
CONV_FRAME_SEQ -- requirements
Module: conv_frame_seq

Interface
REQ-001 Parameter IMG_W, default 50: image width in pixels.
REQ-002 Parameter IMG_H, default 50: image height in pixels.
REQ-003 Parameter PIX_W, default 12: pixel width.
REQ-004 Parameter ADDR_W, default 17: buffer address width.
REQ-005 Parameter TIMEOUT, default 1048575: maximum cycles in WAIT.
REQ-006 Port clk, in, 1: single clock, all logic rising-edge.
REQ-007 Port rst, in, 1: asynchronous, active-low reset.
REQ-008 Port go, in, 1: frame request, sampled in IDLE only.
REQ-009 Port in_valid / in_ready, in / out, 1 each: host pixel stream handshake.
REQ-010 Port in_data, in, PIX_W: host pixel, raster order.
REQ-011 Port ib_we, out, 1: input-buffer write enable.
REQ-012 Port ib_addr, out, ADDR_W: input-buffer write address.
REQ-013 Port ib_wdata, out, PIX_W: input-buffer write data.
REQ-014 Port conv_start, out, 1: one-cycle start pulse to the convolution engine.
REQ-015 Port conv_ready, in, 1: engine done level.
REQ-016 Port ob_addr, out, ADDR_W: output-buffer read address; read latency is 1 cycle.
REQ-017 Port ob_rdata, in, PIX_W: output-buffer read data.
REQ-018 Port out_valid / out_ready, out / in, 1 each: result stream handshake.
REQ-019 Port out_data, out, PIX_W: result pixel, raster order.
REQ-020 Port busy, out, 1: high in every state except IDLE.
REQ-021 Port frame_done, out, 1: one-cycle pulse after the last result pixel is accepted.
REQ-022 Port err, out, 1: sticky timeout flag; cleared on the next accepted go.

Function
REQ-023 The FSM SHALL have states IDLE, LOAD, START, WAIT, DRAIN and DONE.
REQ-024 IDLE->LOAD on go=1; go in any other state SHALL be ignored.
REQ-025 In LOAD, in_ready=1; each in_valid&in_ready beat SHALL produce ib_we=1, ib_addr=pixel count and ib_wdata=in_data in the same cycle.
REQ-026 LOAD->START on the N_PIX-th beat (N_PIX=IMG_W*IMG_H); in_ready SHALL be 0 outside LOAD.
REQ-027 START SHALL last exactly 1 cycle with conv_start=1, then go to WAIT.
REQ-028 WAIT->DRAIN on a conv_ready 0->1 edge, using a registered previous value; a level already high on entry SHALL be ignored.
REQ-029 WAIT SHALL count cycles; reaching TIMEOUT sets err=1 and goes to IDLE without draining.
REQ-030 DRAIN SHALL issue ob_addr=k, present ob_rdata on out_data with out_valid=1 on the following cycle, and hold it stable until out_ready=1.
REQ-031 The next ob_addr SHALL be issued only after the handshake, giving at most 1 pixel per 2 cycles.
REQ-032 DRAIN->DONE on acceptance of pixel N_PIX-1.
REQ-033 DONE SHALL last 1 cycle with frame_done=1, then go to IDLE.
REQ-034 Pixel counters SHALL be ADDR_W wide, clear on IDLE exit and on every state change to DRAIN, and never wrap past N_PIX-1.
REQ-035 out_valid=1 with out_ready=0 SHALL stall indefinitely with no timeout in DRAIN.

Reset
REQ-036 rst=0 SHALL immediately force IDLE, at any point including mid-LOAD or mid-DRAIN.
REQ-037 During reset, in_ready, ib_we, conv_start, out_valid, busy, frame_done and err SHALL all be 0.
REQ-038 During reset, ib_addr, ib_wdata, ob_addr, out_data and all counters SHALL all be 0.
REQ-039 After rst rises, the first go is sampled on the next rising clk edge.

Structure
REQ-040 Package conv_seq_pkg SHALL hold the IMG_W, IMG_H, N_PIX, PIX_W and ADDR_W defaults and the state encoding.
REQ-041 The DRAIN read/handshake stage SHALL be sub-module conv_seq_drain; all other logic stays in conv_frame_seq.

Verification
REQ-042 Test: go, then 2500 beats with in_valid held high -> ib_addr 0..2499 contiguous, conv_start exactly once, 1 cycle after the last beat.
REQ-043 Test: conv_ready already high at WAIT entry, then low 3 cycles, then high -> DRAIN entered only on the rise.
REQ-044 Test: DRAIN with out_ready toggled randomly -> 2500 pixels, out_data[k]=ob model[k], no duplicates or drops, frame_done 1 cycle after the last.
REQ-045 Test: TIMEOUT=100 with conv_ready held 0 -> err=1 at cycle 100 of WAIT, busy=0; the next go clears err.
REQ-046 Test: rst=0 at load beat 1200 -> all outputs 0 that cycle; a fresh frame then starts at ib_addr=0.
REQ-047 Test: go pulsed during WAIT and DRAIN -> no effect; exactly one frame_done per accepted go.
